// File: rtl/uart_mem_dump.sv
// uart_mem_dump: UART readback transmitter for the upg memory map.
//
// On a start request it sends one SYNC_BYTE frame, then reads word_cnt_i 32-bit words
// starting at base_adr_i from a synchronous read port and sends each word as four 8N1
// frames, least significant byte first. Each bit lasts CLK_DIV clocks. Frames within a
// word are back-to-back; the line idles high for the two read cycles between words.
//
// Ports:
//   upg_clk_i   clock, rising edge
//   upg_rst_i   synchronous active-high reset
//   start_i     one-cycle dump request, honoured only when idle
//   base_adr_i  first word address (bit 14 selects data memory)
//   word_cnt_i  number of words to send, 0 sends only the sync byte
//   rd_en_o     memory read strobe, one cycle per word
//   rd_adr_o    memory read address, valid with rd_en_o
//   rd_dat_i    memory read data, valid the cycle after rd_en_o
//   upg_tx_o    UART TX line, idle high
//   busy_o      dump in progress
//   done_o      one-cycle pulse at dump completion
module uart_mem_dump #(
  parameter int unsigned CLK_DIV   = 10,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        upg_clk_i,
  input  logic        upg_rst_i,
  input  logic        start_i,
  input  logic [14:0] base_adr_i,
  input  logic [14:0] word_cnt_i,
  output logic        rd_en_o,
  output logic [14:0] rd_adr_o,
  input  logic [31:0] rd_dat_i,
  output logic        upg_tx_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned BaudW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StRdReq,
    StRdWait,
    StSend,
    StFinish
  } state_e;

  state_e            state_q;
  logic [BaudW-1:0]  baud_q;
  logic [3:0]        bit_idx_q;   // 0 = start bit, 1..8 = data, 9 = stop bit
  logic [1:0]        byte_idx_q;
  logic [14:0]       adr_q;
  logic [14:0]       remain_q;
  logic [31:0]       shift_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_en_q;
  logic [14:0]       rd_adr_q;

  logic [7:0] cur_byte;
  logic       baud_end;
  logic       next_bit;

  // Byte currently on the line: the header during SYNC, else the low byte of the word.
  assign cur_byte = (state_q == StSync) ? SYNC_BYTE : shift_q[7:0];
  assign baud_end = (baud_q == BaudLast);
  // Value of the bit that follows bit_idx_q; bit 8 is followed by the stop bit.
  assign next_bit = (bit_idx_q == 4'd8) ? 1'b1 : cur_byte[bit_idx_q[2:0]];

  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      adr_q      <= '0;
      remain_q   <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_adr_q   <= '0;
    end else begin
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            adr_q     <= base_adr_i;
            remain_q  <= word_cnt_i;
            busy_q    <= 1'b1;
            tx_q      <= 1'b0;  // sync frame start bit begins next cycle
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= StSync;
          end
        end
        StSync, StSend: begin
          if (!baud_end) begin
            baud_q <= baud_q + BaudW'(1);
          end else begin
            baud_q <= '0;
            if (bit_idx_q != 4'd9) begin
              bit_idx_q <= bit_idx_q + 4'd1;
              tx_q      <= next_bit;
            end else if (state_q == StSend && byte_idx_q != 2'd3) begin
              // Next byte of the word starts with no idle gap.
              shift_q    <= {8'h00, shift_q[31:8]};
              byte_idx_q <= byte_idx_q + 2'd1;
              bit_idx_q  <= '0;
              tx_q       <= 1'b0;
            end else if (remain_q == '0) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StFinish;
            end else begin
              rd_en_q  <= 1'b1;
              rd_adr_q <= adr_q;
              state_q  <= StRdReq;
            end
          end
        end
        StRdReq: begin
          state_q <= StRdWait;
        end
        StRdWait: begin
          shift_q    <= rd_dat_i;
          adr_q      <= adr_q + 15'd1;
          remain_q   <= remain_q - 15'd1;
          byte_idx_q <= '0;
          bit_idx_q  <= '0;
          baud_q     <= '0;
          tx_q       <= 1'b0;
          state_q    <= StSend;
        end
        StFinish: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rd_en_o  = rd_en_q;
  assign rd_adr_o = rd_adr_q;
  assign upg_tx_o = tx_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_uart_mem_dump.sv
module tb_uart_mem_dump;

  localparam int DivA = 4;
  localparam int DivB = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, start_b;
  logic [14:0] base_a, base_b, cnt_a, cnt_b;
  logic        rd_en_a, rd_en_b;
  logic [14:0] rd_adr_a, rd_adr_b;
  logic [31:0] rd_dat_a, rd_dat_b;
  logic        tx_a, tx_b, busy_a, busy_b, done_a, done_b;

  uart_mem_dump #(.CLK_DIV(DivA), .SYNC_BYTE(8'hA5)) dut_a (
    .upg_clk_i (clk),
    .upg_rst_i (rst),
    .start_i   (start_a),
    .base_adr_i(base_a),
    .word_cnt_i(cnt_a),
    .rd_en_o   (rd_en_a),
    .rd_adr_o  (rd_adr_a),
    .rd_dat_i  (rd_dat_a),
    .upg_tx_o  (tx_a),
    .busy_o    (busy_a),
    .done_o    (done_a)
  );

  uart_mem_dump #(.CLK_DIV(DivB), .SYNC_BYTE(8'hA5)) dut_b (
    .upg_clk_i (clk),
    .upg_rst_i (rst),
    .start_i   (start_b),
    .base_adr_i(base_b),
    .word_cnt_i(cnt_b),
    .rd_en_o   (rd_en_b),
    .rd_adr_o  (rd_adr_b),
    .rd_dat_i  (rd_dat_b),
    .upg_tx_o  (tx_b),
    .busy_o    (busy_b),
    .done_o    (done_b)
  );

  function automatic logic [31:0] mem_word(input logic [14:0] adr);
    case (adr)
      15'h4010: return 32'h12345678;
      15'h4011: return 32'hDEADBEEF;
      15'h7FFF: return 32'hCAFEF00D;
      15'h0000: return 32'h01020304;
      15'h0100: return 32'h89ABCDEF;
      default:  return 32'h00000000;
    endcase
  endfunction

  // Synchronous read port; junk when not strobed so late or early sampling shows up.
  always @(posedge clk) begin
    rd_dat_a <= rd_en_a ? mem_word(rd_adr_a) : 32'hBAD0BAD0;
    rd_dat_b <= rd_en_b ? mem_word(rd_adr_b) : 32'hBAD0BAD0;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Scoreboard queues: {stop bit, data byte} and read addresses.
  logic [8:0]  exp_byte_q[$];
  logic [14:0] exp_adr_q[$];
  int          done_cnt_a = 0;

  task automatic push_b(input logic [7:0] b);
    exp_byte_q.push_back({1'b1, b});
  endtask

  // UART decoder monitor for dut_a; frames cut by reset are dropped.
  logic [9:0] dec_bits;
  bit         dec_abort;
  initial begin : decoder
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx_a === 1'b0) begin
        dec_bits  = '0;
        dec_abort = 1'b0;
        for (int i = 1; i <= 9 * DivA + DivA / 2; i++) begin
          @(negedge clk);
          if (rst !== 1'b0) dec_abort = 1'b1;
          if (i % DivA == DivA / 2) dec_bits[i / DivA] = tx_a;
        end
        if (!dec_abort) begin
          if (exp_byte_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_byte: got %h, want none", {dec_bits[9], dec_bits[8:1]});
          end else begin
            check("uart_byte", {23'd0, dec_bits[9], dec_bits[8:1]},
                  {23'd0, exp_byte_q.pop_front()});
          end
        end
      end
    end
  end

  // Read-address and done monitors for dut_a.
  always @(negedge clk) begin
    if (rd_en_a === 1'b1) begin
      if (exp_adr_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rd: got %h, want none", rd_adr_a);
      end else begin
        check("rd_adr", {17'd0, rd_adr_a}, {17'd0, exp_adr_q.pop_front()});
      end
    end
    if (done_a === 1'b1) done_cnt_a++;
  end

  // Runs one dump on dut_a and checks done timing, done count and drained queues.
  task automatic run_a(input logic [14:0] base, input logic [14:0] cnt, input int exp_cyc,
                       input bit again);
    int k;
    int d0;
    bit found;
    d0 = done_cnt_a;
    @(posedge clk); #1;
    start_a = 1'b1; base_a = base; cnt_a = cnt;
    @(posedge clk); #1;
    start_a = 1'b0; base_a = 15'h1234; cnt_a = 15'h0003;
    k = 0;
    found = 1'b0;
    while (!found && k < exp_cyc + 100) begin
      @(negedge clk);
      k++;
      start_a = again && (k == 30 || k == 150);
      if (done_a === 1'b1) found = 1'b1;
    end
    start_a = 1'b0;
    check("done_cycle", k, exp_cyc);
    repeat (60) @(negedge clk);
    check("done_count", done_cnt_a - d0, 1);
    check("bytes_pending", exp_byte_q.size(), 0);
    check("adr_pending", exp_adr_q.size(), 0);
  endtask

  bit exp_wave[$];

  task automatic add_frame(input logic [7:0] b);
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < DivB; j++) begin
        exp_wave.push_back((i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1]);
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int k;
    int d0;
    int busy_n;
    int wave_err;
    int first_bad;
    int done_k;
    int rd_n;
    rst = 1'b1;
    start_a = 1'b0; base_a = '0; cnt_a = '0;
    start_b = 1'b0; base_b = '0; cnt_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {31'd0, tx_a}, 1);
    check("rst_busy", {31'd0, busy_a}, 0);
    check("rst_done", {31'd0, done_a}, 0);
    check("rst_rd_en", {31'd0, rd_en_a}, 0);
    check("rst_rd_adr", {17'd0, rd_adr_a}, 0);
    check("rst_tx_b", {31'd0, tx_b}, 1);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Empty dump: sync frame only, done at cycle 1 + 10*4.
    push_b(8'hA5);
    run_a(15'h0000, 15'd0, 41, 1'b0);

    // Two words from data memory.
    push_b(8'hA5);
    push_b(8'h78); push_b(8'h56); push_b(8'h34); push_b(8'h12);
    push_b(8'hEF); push_b(8'hBE); push_b(8'hAD); push_b(8'hDE);
    exp_adr_q.push_back(15'h4010); exp_adr_q.push_back(15'h4011);
    run_a(15'h4010, 15'd2, 365, 1'b0);

    // Address wrap.
    push_b(8'hA5);
    push_b(8'h0D); push_b(8'hF0); push_b(8'hFE); push_b(8'hCA);
    push_b(8'h04); push_b(8'h03); push_b(8'h02); push_b(8'h01);
    exp_adr_q.push_back(15'h7FFF); exp_adr_q.push_back(15'h0000);
    run_a(15'h7FFF, 15'd2, 365, 1'b0);

    // Extra start pulses while busy have no effect.
    push_b(8'hA5);
    push_b(8'h78); push_b(8'h56); push_b(8'h34); push_b(8'h12);
    push_b(8'hEF); push_b(8'hBE); push_b(8'hAD); push_b(8'hDE);
    exp_adr_q.push_back(15'h4010); exp_adr_q.push_back(15'h4011);
    run_a(15'h4010, 15'd2, 365, 1'b1);

    // Reset in the middle of data bit 0 of word 1.
    push_b(8'hA5);
    exp_adr_q.push_back(15'h4010);
    d0 = done_cnt_a;
    @(posedge clk); #1;
    start_a = 1'b1; base_a = 15'h4010; cnt_a = 15'd2;
    @(posedge clk); #1;
    start_a = 1'b0;
    k = 0;
    while (rd_en_a !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("rd_en_seen", {31'd0, rd_en_a}, 1);
    @(posedge clk);          // RD_WAIT
    @(posedge clk);          // start bit begins
    repeat (DivA + 1) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_tx", {31'd0, tx_a}, 1);
    check("abort_busy", {31'd0, busy_a}, 0);
    check("abort_done", {31'd0, done_a}, 0);
    repeat (60) @(negedge clk);
    check("abort_done_count", done_cnt_a - d0, 0);
    check("abort_bytes_pending", exp_byte_q.size(), 0);
    check("abort_adr_pending", exp_adr_q.size(), 0);

    // Fresh dump after the abort.
    push_b(8'hA5);
    push_b(8'h04); push_b(8'h03); push_b(8'h02); push_b(8'h01);
    exp_adr_q.push_back(15'h0000);
    run_a(15'h0000, 15'd1, 203, 1'b0);

    // CLK_DIV=10, one word: cycle-exact line waveform and busy length.
    add_frame(8'hA5);
    exp_wave.push_back(1'b1); exp_wave.push_back(1'b1);
    add_frame(8'hEF); add_frame(8'hCD); add_frame(8'hAB); add_frame(8'h89);
    @(posedge clk); #1;
    start_b = 1'b1; base_b = 15'h0100; cnt_b = 15'd1;
    @(posedge clk); #1;
    start_b = 1'b0; base_b = 15'h0555; cnt_b = 15'd7;
    busy_n = 0; wave_err = 0; first_bad = -1; done_k = 0; rd_n = 0;
    for (int c = 1; c <= 503; c++) begin
      @(negedge clk);
      if (c <= 502 && c <= exp_wave.size()) begin
        if (tx_b !== exp_wave[c-1]) begin
          wave_err++;
          if (first_bad < 0) first_bad = c;
        end
      end
      if (busy_b === 1'b1) busy_n++;
      if (done_b === 1'b1 && done_k == 0) done_k = c;
      if (rd_en_b === 1'b1) begin
        rd_n++;
        check("rd_adr_b", {17'd0, rd_adr_b}, 32'h0100);
      end
    end
    check("wave_len", exp_wave.size(), 502);
    check("wave_errors", wave_err, 0);
    if (wave_err != 0) $display("first waveform difference at cycle %0d", first_bad);
    check("busy_cycles", busy_n, 502);
    check("done_cycle_b", done_k, 503);
    check("rd_count_b", rd_n, 1);
    check("idle_tx_b", {31'd0, tx_b}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_mem_dump.md
Name: uart_mem_dump

Overview:
- UART readback transmitter. It is the reverse direction of the UART programmer path.
- On command, reads a block of 32-bit words from a synchronous memory read port (program ROM or data memory, using the same 15-bit upg address map where bit 14=1 selects data memory) and serialises them on a TX line as 8N1 frames.
- Sits beside the programmer in the CPU top, clocked on the programmer clock domain. Used to dump or verify memory contents after a download.

Parameters:
- CLK_DIV, 10, clock cycles per UART bit (>=2).
- SYNC_BYTE, 8'hA5, header byte sent once before the first word of every dump.

Ports:
- upg_clk_i  input  1  single clock, rising edge.
- upg_rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  one-cycle dump request; sampled only in IDLE.
- base_adr_i  input  15  first word address (bit 14 = bank select, as upg_adr).
- word_cnt_i  input  15  number of words to send; 0 = none.
- rd_en_o  output  1  memory read strobe, one cycle per word.
- rd_adr_o  output  15  memory read address, valid while rd_en_o=1.
- rd_dat_i  input  32  memory read data; valid exactly 1 cycle after rd_en_o.
- upg_tx_o  output  1  UART TX line, idle high.
- busy_o  output  1  high from the cycle after start acceptance until done.
- done_o  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset, and any cycle where upg_rst_i=1:
  - Next edge: state=IDLE, upg_tx_o=1, busy_o=0, done_o=0, rd_en_o=0, rd_adr_o=0, all counters cleared.
  - Reset mid-frame aborts immediately. No stop bit is completed and no done_o is pulsed.
- States: IDLE, SYNC, RD_REQ, RD_WAIT, SEND, FINISH.
- IDLE:
  - When start_i=1, latch base_adr_i into an address counter and word_cnt_i into a remaining counter; go to SYNC; busy_o=1 from the next cycle.
  - start_i in any other state is ignored.
- SYNC: transmit SYNC_BYTE as one frame. Then:
  - remaining=0 -> FINISH.
  - otherwise -> RD_REQ.
- RD_REQ: rd_en_o=1 and rd_adr_o=address for exactly one cycle -> RD_WAIT.
- RD_WAIT: latch rd_dat_i into a 32-bit shift register; address+1 (15-bit, wraps 0x7FFF->0x0000); remaining-1 -> SEND.
- SEND:
  - Transmit 4 frames back-to-back, least significant byte first (bits [7:0], [15:8], [23:16], [31:24]).
  - No idle cycles between the 4 frames.
  - After the 4th stop bit: remaining=0 -> FINISH, else -> RD_REQ.
- FINISH: done_o=1 for one cycle, busy_o=0 in the same cycle -> IDLE.
- Frame format:
  - Start bit 0, 8 data bits LSB first, stop bit 1.
  - Each bit is held on upg_tx_o for exactly CLK_DIV cycles. One frame = 10*CLK_DIV cycles.
  - A baud counter counts 0..CLK_DIV-1 and advances the bit index on terminal count.
- Line during non-frame cycles: between words upg_tx_o=1 for exactly 2 cycles (RD_REQ, RD_WAIT); upg_tx_o=1 in IDLE and FINISH.
- Timing:
  - The start bit of the SYNC frame begins the cycle after start_i is accepted.
  - Total dump length = 1 (accept) + 10*CLK_DIV*(1+4N) + 2N cycles, then the done_o cycle, for N words.
- upg_tx_o is driven from a register (glitch-free). rd_adr_o and rd_en_o are registered.
- base_adr_i and word_cnt_i may change after acceptance with no effect on the current dump.

Test Plan:
- CLK_DIV=4, start_i with base=0x0000, cnt=0:
  - SYNC frame 0xA5 appears (bit sequence 0,1,0,1,0,0,1,0,1,1, each 4 cycles).
  - done_o pulses at cycle 41 after acceptance; rd_en_o never asserts.
- CLK_DIV=4, base=0x4010, cnt=2, memory returns 0x12345678 then 0xDEADBEEF:
  - rd_adr_o=0x4010 then 0x4011.
  - Bytes decoded: A5 78 56 34 12 EF BE AD DE.
  - Exactly 2 idle-high cycles before each word; done_o once.
- Wrap-around: base=0x7FFF, cnt=2 -> rd_adr_o sequence 0x7FFF, 0x0000.
- start_i pulsed again while busy_o=1 -> ignored. Byte stream and done_o count are unchanged from the single-dump case.
- upg_rst_i asserted mid-data-bit of word 1:
  - Next cycle upg_tx_o=1, busy_o=0, no done_o.
  - A fresh start_i afterwards produces a correct complete dump.
- CLK_DIV=10, cnt=1: measure that each bit is held exactly 10 cycles and that total busy time matches the formula (1+50*... = 10*10*5+2 cycles of frame/read activity).
